// File: rtl/pulse_burst_generator_pkg.sv
// Shared types and width helpers for the pulse burst generator and related timing blocks.
package pulse_burst_generator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_e;

   // $clog2 clamped to at least one bit so single-value counters still get a register
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned w;
      w = unsigned'($clog2(value));
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pulse_burst_generator_if.sv
// Trigger-in / waveform-out bundle of the pulse burst generator.
interface pulse_burst_generator_if #(
   parameter int unsigned PEND_W = 1
);
   logic              i_trig;
   logic              o_pulse;
   logic              o_busy;
   logic              o_done;
   logic              o_overflow;
   logic [PEND_W-1:0] o_pending;

   modport master (
      output i_trig,
      input  o_pulse, o_busy, o_done, o_overflow, o_pending
   );

   modport slave (
      input  i_trig,
      output o_pulse, o_busy, o_done, o_overflow, o_pending
   );
endinterface

// File: rtl/load_down_counter.sv
// Loadable down counter that holds at zero; o_zero flags the terminal count.
module load_down_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_en,
   output logic             o_zero
);
   logic [WIDTH-1:0] count;

   // load wins over decrement; never wraps below zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_load) begin
         count <= i_value;
      end else if (i_en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign o_zero = (count == '0);
endmodule

// File: rtl/pulse_burst_generator.sv
// Expands 1-cycle triggers into bursts of timed pulses; triggers seen while busy are queued and replayed.
module pulse_burst_generator
   import pulse_burst_generator_pkg::*;
#(
   parameter int unsigned HIGH_CYCLES = 4,
   parameter int unsigned LOW_CYCLES  = 4,
   parameter int unsigned NUM_PULSES  = 1,
   parameter int unsigned MAX_PENDING = 3,
   parameter bit          IS_POSITIVE = 1'b1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   pulse_burst_generator_if.slave bus
);
   localparam int unsigned PHASE_W = clog2_min1(max_u(HIGH_CYCLES, LOW_CYCLES));
   localparam int unsigned PULSE_W = clog2_min1(NUM_PULSES);
   localparam int unsigned PEND_W  = clog2_min1(MAX_PENDING + 1);

   localparam logic [PHASE_W-1:0] HIGH_LOAD  = PHASE_W'(HIGH_CYCLES - 1);
   localparam logic [PHASE_W-1:0] LOW_LOAD   = PHASE_W'(LOW_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(NUM_PULSES - 1);
   localparam logic [PEND_W-1:0]  PEND_MAX   = PEND_W'(MAX_PENDING);

   if (HIGH_CYCLES < 1) begin : g_bad_high
      $error("pulse_burst_generator: HIGH_CYCLES must be >= 1");
   end
   if (LOW_CYCLES < 1) begin : g_bad_low
      $error("pulse_burst_generator: LOW_CYCLES must be >= 1");
   end
   if (NUM_PULSES < 1) begin : g_bad_num
      $error("pulse_burst_generator: NUM_PULSES must be >= 1");
   end

   state_e              state;
   state_e              next_state;
   logic                phase_zero;
   logic                pulse_zero;
   logic                phase_load;
   logic                phase_en;
   logic [PHASE_W-1:0]  phase_value;
   logic                pulse_load;
   logic                pulse_en;
   logic                last_gap;
   logic [PEND_W-1:0]   pending;
   logic [PEND_W-1:0]   pending_next;
   logic                overflow_next;
   logic                overflow_q;
   logic                pulse_q;

   load_down_counter #(.WIDTH(PHASE_W)) u_phase_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (phase_load),
      .i_value (phase_value),
      .i_en    (phase_en),
      .o_zero  (phase_zero)
   );

   load_down_counter #(.WIDTH(PULSE_W)) u_pulse_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (pulse_load),
      .i_value (PULSE_LOAD),
      .i_en    (pulse_en),
      .o_zero  (pulse_zero)
   );

   // final LOW cycle of the last pulse in a burst
   assign last_gap = (state == ST_GAP) && phase_zero && pulse_zero;

   always_comb begin
      next_state    = state;
      phase_load    = 1'b0;
      phase_value   = HIGH_LOAD;
      phase_en      = 1'b0;
      pulse_load    = 1'b0;
      pulse_en      = 1'b0;
      pending_next  = pending;
      overflow_next = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.i_trig) begin
               next_state = ST_ACTIVE;
               phase_load = 1'b1;
               pulse_load = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (phase_zero) begin
               next_state  = ST_GAP;
               phase_load  = 1'b1;
               phase_value = LOW_LOAD;
            end else begin
               phase_en = 1'b1;
            end
         end
         ST_GAP: begin
            if (!phase_zero) begin
               phase_en = 1'b1;
            end else if (!pulse_zero) begin
               next_state = ST_ACTIVE;
               phase_load = 1'b1;
               pulse_en   = 1'b1;
            end else if (bus.i_trig) begin
               // a fresh trigger starts the next burst and leaves the queue alone
               next_state = ST_ACTIVE;
               phase_load = 1'b1;
               pulse_load = 1'b1;
            end else if (pending != '0) begin
               next_state   = ST_ACTIVE;
               phase_load   = 1'b1;
               pulse_load   = 1'b1;
               pending_next = pending - PEND_W'(1);
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase

      // queue or drop triggers that did not start a burst this cycle
      if (bus.i_trig && (state != ST_IDLE) && !last_gap) begin
         if (pending < PEND_MAX) begin
            pending_next = pending + PEND_W'(1);
         end else begin
            overflow_next = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         pending    <= '0;
         overflow_q <= 1'b0;
         pulse_q    <= ~IS_POSITIVE;
      end else begin
         state      <= next_state;
         pending    <= pending_next;
         overflow_q <= overflow_next;
         pulse_q    <= (next_state == ST_ACTIVE) ? IS_POSITIVE : ~IS_POSITIVE;
      end
   end

   assign bus.o_pulse    = pulse_q;
   assign bus.o_busy     = (state != ST_IDLE);
   assign bus.o_done     = last_gap;
   assign bus.o_overflow = overflow_q;
   assign bus.o_pending  = pending;
endmodule

// File: tb/tb_pulse_burst_generator.sv
// Directed bench: per-cycle waveform tables for two parameterisations plus a held-trigger sequence.
module tb_pulse_burst_generator;

   typedef struct {
      bit          use_b;
      logic [39:0] rst;
      logic [39:0] trig;
      logic [39:0] active;
      logic [39:0] busy;
      logic [39:0] done;
      logic [39:0] ovf;
      logic [39:0] pend0;
      logic [39:0] pend1;
      int          ncyc;
   } vec_t;

   localparam int NVEC = 7;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   pulse_burst_generator_if #(.PEND_W(2)) if_a ();
   pulse_burst_generator_if #(.PEND_W(1)) if_b ();

   pulse_burst_generator #(
      .HIGH_CYCLES (3),
      .LOW_CYCLES  (2),
      .NUM_PULSES  (2),
      .MAX_PENDING (2),
      .IS_POSITIVE (1'b1)
   ) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if_a)
   );

   pulse_burst_generator #(
      .HIGH_CYCLES (1),
      .LOW_CYCLES  (1),
      .NUM_PULSES  (1),
      .MAX_PENDING (1),
      .IS_POSITIVE (1'b0)
   ) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if_b)
   );

   function automatic logic [39:0] rng(input int lo, input int hi);
      logic [39:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m = m | (40'd1 << i);
      return m;
   endfunction

   function automatic logic at(input logic [39:0] m, input int c);
      logic [39:0] s;
      s = m >> c;
      return s[0];
   endfunction

   task automatic check(input string what, input int v, input int c,
                        input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s vec%0d cycle%0d: got %0d, want %0d", what, v, c, got, want);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_a.i_trig = 1'b0;
      if_b.i_trig = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_vec(input int v);
      logic [31:0] p, b, d, o, pe;
      logic        exp_p;
      do_reset();
      for (int c = 0; c < vecs[v].ncyc; c++) begin
         rst = at(vecs[v].rst, c);
         if (vecs[v].use_b) if_b.i_trig = at(vecs[v].trig, c);
         else               if_a.i_trig = at(vecs[v].trig, c);
         @(negedge clk);
         if (vecs[v].use_b) begin
            p = 32'(if_b.o_pulse); b = 32'(if_b.o_busy); d = 32'(if_b.o_done);
            o = 32'(if_b.o_overflow); pe = 32'(if_b.o_pending);
            exp_p = ~at(vecs[v].active, c);
         end else begin
            p = 32'(if_a.o_pulse); b = 32'(if_a.o_busy); d = 32'(if_a.o_done);
            o = 32'(if_a.o_overflow); pe = 32'(if_a.o_pending);
            exp_p = at(vecs[v].active, c);
         end
         check("pulse",    v, c, p,  32'(exp_p));
         check("busy",     v, c, b,  32'(at(vecs[v].busy, c)));
         check("done",     v, c, d,  32'(at(vecs[v].done, c)));
         check("overflow", v, c, o,  32'(at(vecs[v].ovf, c)));
         check("pending",  v, c, pe, 32'({at(vecs[v].pend1, c), at(vecs[v].pend0, c)}));
         @(posedge clk);
         #1;
      end
      if_a.i_trig = 1'b0;
      if_b.i_trig = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      logic [39:0] three_bursts;
      int n_done, n_ovf, n_rise, max_pend;
      logic prev_p;

      clk = 1'b0;
      rst = 1'b1;
      if_a.i_trig = 1'b0;
      if_b.i_trig = 1'b0;
      n_checks = 0;
      n_pass = 0;

      three_bursts = rng(1,3) | rng(6,8) | rng(11,13) | rng(16,18) | rng(21,23) | rng(26,28);

      // single burst
      vecs[0] = '{use_b:1'b0, rst:'0, trig:rng(0,0), active:rng(1,3) | rng(6,8),
                  busy:rng(1,10), done:rng(10,10), ovf:'0, pend0:'0, pend1:'0, ncyc:14};
      // two queued triggers replayed back-to-back
      vecs[1] = '{use_b:1'b0, rst:'0, trig:rng(0,0) | rng(4,5), active:three_bursts,
                  busy:rng(1,30), done:rng(10,10) | rng(20,20) | rng(30,30), ovf:'0,
                  pend0:rng(5,5) | rng(11,20), pend1:rng(6,10), ncyc:34};
      // queue saturates, two drops
      vecs[2] = '{use_b:1'b0, rst:'0, trig:rng(0,0) | rng(2,5), active:three_bursts,
                  busy:rng(1,30), done:rng(10,10) | rng(20,20) | rng(30,30), ovf:rng(5,6),
                  pend0:rng(3,3) | rng(11,20), pend1:rng(4,10), ncyc:34};
      // trigger in the done cycle chains directly
      vecs[3] = '{use_b:1'b0, rst:'0, trig:rng(0,0) | rng(10,10),
                  active:rng(1,3) | rng(6,8) | rng(11,13) | rng(16,18),
                  busy:rng(1,20), done:rng(10,10) | rng(20,20), ovf:'0, pend0:'0, pend1:'0, ncyc:24};
      // reset mid-burst with a trigger and a queued entry
      vecs[4] = '{use_b:1'b0, rst:rng(5,5), trig:rng(0,0) | rng(4,5), active:rng(1,3),
                  busy:rng(1,5), done:'0, ovf:'0, pend0:rng(5,5), pend1:'0, ncyc:14};
      // active-low, minimal timing
      vecs[5] = '{use_b:1'b1, rst:'0, trig:rng(0,0), active:rng(1,1),
                  busy:rng(1,2), done:rng(2,2), ovf:'0, pend0:'0, pend1:'0, ncyc:6};
      // same-cycle trigger beats queue at burst end, then overflow with queue full
      vecs[6] = '{use_b:1'b1, rst:'0, trig:rng(0,3), active:rng(1,1) | rng(3,3) | rng(5,5),
                  busy:rng(1,6), done:rng(2,2) | rng(4,4) | rng(6,6), ovf:rng(4,4),
                  pend0:rng(2,4), pend1:'0, ncyc:10};

      for (int v = 0; v < NVEC; v++) run_vec(v);

      // trigger asserted during reset is discarded
      rst = 1'b1;
      if_a.i_trig = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if_a.i_trig = 1'b0;
      @(negedge clk);
      check("rst_trig_busy",    90, 0, 32'(if_a.o_busy),    32'd0);
      check("rst_trig_pending", 90, 0, 32'(if_a.o_pending), 32'd0);
      @(posedge clk);
      #1;

      // level held for 10 cycles: 1 burst + 2 queued + 7 drops
      n_done = 0; n_ovf = 0; n_rise = 0; max_pend = 0; prev_p = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if_a.i_trig = (c < 10);
         @(negedge clk);
         if (if_a.o_done === 1'b1) n_done++;
         if (if_a.o_overflow === 1'b1) n_ovf++;
         if ((if_a.o_pulse === 1'b1) && !prev_p) n_rise++;
         prev_p = (if_a.o_pulse === 1'b1);
         if (int'(if_a.o_pending) > max_pend) max_pend = int'(if_a.o_pending);
         @(posedge clk);
         #1;
      end
      if_a.i_trig = 1'b0;
      check("held_done_count",  91, 40, 32'(n_done),      32'd3);
      check("held_ovf_count",   91, 40, 32'(n_ovf),       32'd7);
      check("held_pulse_count", 91, 40, 32'(n_rise),      32'd6);
      check("held_max_pending", 91, 40, 32'(max_pend),    32'd2);
      check("held_busy_end",    91, 40, 32'(if_a.o_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
